// File: rtl/uart_tx_param_pkg.sv
// Shared UART types and constants: FSM states, parity codes, baud divisor rounding.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package uart_tx_param_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } state_t;

    localparam int PAR_NONE = 0;
    localparam int PAR_ODD  = 1;
    localparam int PAR_EVEN = 2;

    // Clocks per bit, rounded to nearest; the receiver reuses this so both ends agree.
    function automatic int baud_div(input int clk_freq, input int baud);
        return (clk_freq + baud / 2) / baud;
    endfunction

endpackage

// File: rtl/uart_tx_param_if.sv
// Valid/ready word interface between the byte producer and the UART transmitter.
// Latency: n/a (wires only).
// Backpressure: the word moves on a clk edge where tx_valid & tx_ready.
// Ports: tx_data (word, LSB sent first), tx_valid (producer), tx_ready (transmitter FIFO not full).
interface uart_tx_param_if #(
    parameter int DATA_BITS = 8
);
    logic [DATA_BITS-1:0] tx_data;
    logic                 tx_valid;
    logic                 tx_ready;

    modport master (output tx_data, output tx_valid, input  tx_ready);
    modport slave  (input  tx_data, input  tx_valid, output tx_ready);
endinterface

// File: rtl/uart_tx_param_fifo.sv
// Synchronous FIFO holding words waiting for the serialiser.
// Latency: a pushed word is visible at pop_dat one clk after the push edge.
// Backpressure: rdy = not full; pushes while full are dropped, pops while empty are ignored.
// Ports: clk, rst_n (async active-low flush), push/push_dat/rdy, pop/pop_dat, level (occupancy).
module uart_tx_param_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_dat,
    output logic                     rdy,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_dat,
    output logic [$clog2(DEPTH):0]   level
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]    level_q, level_d;
    logic             push_ok;
    logic             pop_ok;

    // Full is judged on the registered count, so a push alongside a pop while full is refused.
    assign rdy     = (level_q != LW'(DEPTH));
    assign push_ok = push && rdy;
    assign pop_ok  = pop && (level_q != '0);
    assign pop_dat = mem_q[rd_ptr_q];
    assign level   = level_q;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push_ok) begin
            mem_d[wr_ptr_q] = push_dat;
            wr_ptr_d        = wr_ptr_q + 1'b1;   // power-of-2 depth: wraps naturally
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        level_d = level_q + LW'(push_ok) - LW'(pop_ok);
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

endmodule

// File: rtl/uart_tx_param.sv
// Parametrised UART transmitter (DATA_BITS, parity, STOP_BITS, baud) fed by a small FIFO; frames run back-to-back.
// Latency: start bit begins one clk after the edge that pops a word; every bit lasts exactly BAUD_DIV clks.
// Backpressure: in_if.tx_ready drops while the FIFO is full; the line itself never stalls.
// Ports: clk, rst (async active-low), in_if (slave word input), tx (serial, idles high),
//        busy (start bit through last stop bit), level (FIFO occupancy).
module uart_tx_param
    import uart_tx_param_pkg::*;
#(
    parameter int CLK_FREQ   = 50_000_000,
    parameter int BAUD       = 9600,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    uart_tx_param_if.slave                in_if,
    output logic                          tx,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   level
);
    localparam int BAUD_DIV  = baud_div(CLK_FREQ, BAUD);
    localparam int STOP_CLKS = STOP_BITS * BAUD_DIV;
    localparam int CW        = $clog2(STOP_CLKS);

    localparam logic [CW-1:0] BIT_LAST  = CW'(BAUD_DIV - 1);
    localparam logic [CW-1:0] STOP_LAST = CW'(STOP_CLKS - 1);
    localparam logic [3:0]    DATA_LAST = 4'(DATA_BITS - 1);

    if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
        $error("uart_tx_param: DATA_BITS must be 5..9");
    end
    if (PARITY < PAR_NONE || PARITY > PAR_EVEN) begin : g_bad_parity
        $error("uart_tx_param: PARITY must be 0, 1 or 2");
    end
    if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop_bits
        $error("uart_tx_param: STOP_BITS must be 1 or 2");
    end
    if (BAUD_DIV < 2) begin : g_bad_baud_div
        $error("uart_tx_param: BAUD_DIV must be at least 2");
    end
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("uart_tx_param: FIFO_DEPTH must be a power of 2, at least 2");
    end

    logic [DATA_BITS-1:0] head;
    logic                 pop;
    logic                 load;
    logic                 fifo_nempty;
    logic                 head_par;

    uart_tx_param_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (DATA_BITS)
    ) u_fifo (
        .clk      (clk),
        .rst_n    (rst),
        .push     (in_if.tx_valid),
        .push_dat (in_if.tx_data),
        .rdy      (in_if.tx_ready),
        .pop      (pop),
        .pop_dat  (head),
        .level    (level)
    );

    assign fifo_nempty = (level != '0);
    // Parity is fixed at load time so the shift register can be consumed freely.
    assign head_par    = (PARITY == PAR_ODD) ? ~^head : ^head;

    state_t               state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [3:0]           bit_q, bit_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 par_q, par_d;
    logic                 tx_q, tx_d;
    logic                 busy_q, busy_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        par_d   = par_q;
        tx_d    = tx_q;
        busy_d  = busy_q;
        load    = 1'b0;
        pop     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                tx_d   = 1'b1;
                busy_d = 1'b0;
                load   = fifo_nempty;
            end
            ST_START: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d   = '0;
                    bit_d   = '0;
                    tx_d    = shift_q[0];
                    state_d = ST_DATA;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_DATA: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d = '0;
                    if (bit_q == DATA_LAST) begin
                        if (PARITY != PAR_NONE) begin
                            tx_d    = par_q;
                            state_d = ST_PARITY;
                        end else begin
                            tx_d    = 1'b1;
                            state_d = ST_STOP;
                        end
                    end else begin
                        bit_d   = bit_q + 4'd1;
                        shift_d = shift_q >> 1;
                        tx_d    = shift_q[1];
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_PARITY: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d   = '0;
                    tx_d    = 1'b1;
                    state_d = ST_STOP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_STOP: begin
                // The whole stop period is one count so STOP_BITS=2 needs no extra state.
                if (cnt_q == STOP_LAST) begin
                    if (fifo_nempty) begin
                        load = 1'b1;
                    end else begin
                        tx_d    = 1'b1;
                        busy_d  = 1'b0;
                        state_d = ST_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Shared by IDLE and the last stop clock, which gives back-to-back frames with no gap.
        if (load) begin
            pop     = 1'b1;
            shift_d = head;
            par_d   = head_par;
            tx_d    = 1'b0;
            busy_d  = 1'b1;
            cnt_d   = '0;
            state_d = ST_START;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            par_q   <= 1'b0;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            par_q   <= par_d;
            tx_q    <= tx_d;
            busy_q  <= busy_d;
        end
    end

    assign tx   = tx_q;
    assign busy = busy_q;

endmodule

// File: tb/tb_uart_tx_param.sv
// Bench for uart_tx_param: five instances (8N1, 8E1, 8O1, 7O2 at 5 Mbaud, defaults at 9600).
// Latency: n/a.
// Backpressure: stimulus holds tx_valid until tx_ready accepts the word.
module tb_uart_tx_param;

    typedef struct {
        logic [15:0] bits;   // line order, first bit in the MSB of the n-bit field
        int          n;
    } exp_t;

    logic       clk = 1'b0;
    int         cyc = 0;
    int         n_checks = 0;
    int         n_fail = 0;

    logic       rst_n [5];
    logic [8:0] d     [5];
    logic       v     [5];
    logic       rdy   [5];
    logic       tx_w  [5];
    logic       busy_w[5];
    logic [2:0] level_w[5];

    exp_t       exp_q    [5][$];
    int         start_log[5][$];

    always #10 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    uart_tx_param_if #(.DATA_BITS(8)) if0 ();
    uart_tx_param_if #(.DATA_BITS(8)) if1 ();
    uart_tx_param_if #(.DATA_BITS(8)) if2 ();
    uart_tx_param_if #(.DATA_BITS(7)) if3 ();
    uart_tx_param_if #(.DATA_BITS(8)) if4 ();

    assign if0.tx_data = d[0][7:0]; assign if0.tx_valid = v[0]; assign rdy[0] = if0.tx_ready;
    assign if1.tx_data = d[1][7:0]; assign if1.tx_valid = v[1]; assign rdy[1] = if1.tx_ready;
    assign if2.tx_data = d[2][7:0]; assign if2.tx_valid = v[2]; assign rdy[2] = if2.tx_ready;
    assign if3.tx_data = d[3][6:0]; assign if3.tx_valid = v[3]; assign rdy[3] = if3.tx_ready;
    assign if4.tx_data = d[4][7:0]; assign if4.tx_valid = v[4]; assign rdy[4] = if4.tx_ready;

    uart_tx_param #(.BAUD(5_000_000), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4)) u_a (
        .clk(clk), .rst(rst_n[0]), .in_if(if0), .tx(tx_w[0]), .busy(busy_w[0]), .level(level_w[0]));
    uart_tx_param #(.BAUD(5_000_000), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1), .FIFO_DEPTH(4)) u_b (
        .clk(clk), .rst(rst_n[1]), .in_if(if1), .tx(tx_w[1]), .busy(busy_w[1]), .level(level_w[1]));
    uart_tx_param #(.BAUD(5_000_000), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1), .FIFO_DEPTH(4)) u_c (
        .clk(clk), .rst(rst_n[2]), .in_if(if2), .tx(tx_w[2]), .busy(busy_w[2]), .level(level_w[2]));
    uart_tx_param #(.BAUD(5_000_000), .DATA_BITS(7), .PARITY(1), .STOP_BITS(2), .FIFO_DEPTH(4)) u_d (
        .clk(clk), .rst(rst_n[3]), .in_if(if3), .tx(tx_w[3]), .busy(busy_w[3]), .level(level_w[3]));
    uart_tx_param #(.CLK_FREQ(50_000_000), .BAUD(9600), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1),
                    .FIFO_DEPTH(4)) u_e (
        .clk(clk), .rst(rst_n[4]), .in_if(if4), .tx(tx_w[4]), .busy(busy_w[4]), .level(level_w[4]));

    task automatic check(input string name, input longint got, input longint want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got 'h%0h, want 'h%0h", name, got, want);
        end
    endtask

    function automatic int get_start(input int id, input int k);
        if (k < start_log[id].size()) return start_log[id][k];
        return -100000;
    endfunction

    // Scoreboard producer: queues the expected line pattern (n=0: word is expected to be flushed).
    task automatic push(input int id, input logic [8:0] data, input logic [15:0] bits, input int n,
                        input int budget, output int acc);
        exp_t e;
        bit   ok;
        if (n > 0) begin
            e.bits = bits;
            e.n    = n;
            exp_q[id].push_back(e);
        end
        d[id] = data;
        v[id] = 1'b1;
        ok    = 1'b0;
        acc   = -1;
        for (int i = 0; i < budget; i++) begin
            if (rdy[id] === 1'b1) begin
                @(posedge clk); #1;
                acc = cyc;
                ok  = 1'b1;
                break;
            end
            @(posedge clk); #1;
        end
        v[id] = 1'b0;
        check($sformatf("push_accept_%0d", id), longint'(ok), 1);
    endtask

    task automatic busy_len(input int id, input int budget, output int len);
        int i;
        len = 0;
        i   = 0;
        while (busy_w[id] !== 1'b1 && i < budget) begin @(negedge clk); i++; end
        while (busy_w[id] === 1'b1 && i < budget) begin @(negedge clk); i++; len++; end
    endtask

    task automatic wait_idle(input int id, input int budget, output int at_cyc);
        int i;
        i = 0;
        at_cyc = -1;
        while (busy_w[id] !== 1'b0 && i < budget) begin @(negedge clk); i++; end
        if (busy_w[id] === 1'b0) at_cyc = cyc;
    endtask

    // Scoreboard consumer: on each start bit pop an expectation, sample the first and last clk of
    // every bit so both value and exact bit width are compared.
    task automatic mon(input int id, input int div);
        exp_t        e;
        logic [15:0] got_f;
        logic [15:0] got_l;
        forever begin
            @(negedge clk);
            if (tx_w[id] === 1'b0) begin
                start_log[id].push_back(cyc);
                if (exp_q[id].size() == 0) begin
                    check($sformatf("unexpected_frame_%0d", id), longint'(cyc), -1);
                    while (tx_w[id] === 1'b0) @(negedge clk);
                end else begin
                    e     = exp_q[id].pop_front();
                    got_f = '0;
                    got_l = '0;
                    for (int k = 0; k < e.n; k++) begin
                        for (int c = 0; c < div; c++) begin
                            if (k != 0 || c != 0) @(negedge clk);
                            if (c == 0)       got_f = {got_f[14:0], tx_w[id]};
                            if (c == div - 1) got_l = {got_l[14:0], tx_w[id]};
                        end
                    end
                    check($sformatf("frame_bits_%0d", id), longint'(got_f), longint'(e.bits));
                    check($sformatf("frame_hold_%0d", id), longint'(got_l), longint'(e.bits));
                end
            end
        end
    endtask

    initial begin
        fork
            mon(0, 10);
            mon(1, 10);
            mon(2, 10);
            mon(3, 10);
            mon(4, 5208);
        join_none
    end

    initial begin
        int acc, len, low, n0, t_end, bad;
        for (int i = 0; i < 5; i++) begin
            rst_n[i] = 1'b0;
            v[i]     = 1'b0;
            d[i]     = '0;
        end

        // Reset held with a word offered: nothing may be taken.
        v[0] = 1'b1;
        d[0] = 9'h033;
        repeat (2) @(negedge clk);
        check("rst_tx",    longint'(tx_w[0]),    1);
        check("rst_busy",  longint'(busy_w[0]),  0);
        check("rst_level", longint'(level_w[0]), 0);
        check("rst_ready", longint'(rdy[0]),     1);
        repeat (3) @(negedge clk);
        v[0] = 1'b0;
        check("rst_no_accept", longint'(level_w[0]), 0);
        @(negedge clk);
        for (int i = 0; i < 5; i++) rst_n[i] = 1'b1;
        low = 0;
        repeat (5) begin @(negedge clk); if (tx_w[0] !== 1'b1) low++; end
        check("post_rst_tx_low_clks", low, 0);
        check("post_rst_level", longint'(level_w[0]), 0);

        fork
            begin : seq_a
                int a_acc, a_len, a_low, a_n0, a_end, a_bad;
                // 8N1, 8'hA5
                a_n0 = start_log[0].size();
                push(0, 9'h0A5, 16'b0101001011, 10, 50, a_acc);
                @(negedge clk);
                check("a5_tx_before_start", longint'(tx_w[0]), 1);
                busy_len(0, 300, a_len);
                check("a5_busy_clks", a_len, 100);
                check("a5_start_delay", get_start(0, a_n0) - a_acc, 1);

                // Five words back-to-back, sixth stalls on a full FIFO.
                repeat (3) @(negedge clk);
                a_n0 = start_log[0].size();
                push(0, 9'h001, 16'b0100000001, 10, 5, a_acc);
                push(0, 9'h002, 16'b0010000001, 10, 5, a_acc);
                push(0, 9'h003, 16'b0110000001, 10, 5, a_acc);
                push(0, 9'h004, 16'b0001000001, 10, 5, a_acc);
                push(0, 9'h005, 16'b0101000001, 10, 5, a_acc);
                check("b2b_level_full", longint'(level_w[0]), 4);
                check("b2b_ready_low",  longint'(rdy[0]),     0);
                push(0, 9'h006, 16'b0011000001, 10, 300, a_acc);
                check("b2b_stall_release", a_acc - get_start(0, a_n0), 101);
                wait_idle(0, 1000, a_end);
                check("b2b_five_frame_span", get_start(0, a_n0 + 5) - get_start(0, a_n0), 500);
                a_bad = 0;
                for (int k = 1; k <= 5; k++)
                    if (get_start(0, a_n0 + k) - get_start(0, a_n0 + k - 1) != 100) a_bad++;
                check("b2b_gapped_frames", a_bad, 0);
                check("b2b_busy_end", a_end - get_start(0, a_n0 + 5), 100);

                // Reset during data bit 3 of 8'hFF with two words queued behind it.
                repeat (3) @(negedge clk);
                push(0, 9'h0FF, 16'b0111111111, 10, 5, a_acc);
                push(0, 9'h011, 16'h0, 0, 5, a_acc);
                push(0, 9'h022, 16'h0, 0, 5, a_acc);
                check("midrst_queued", longint'(level_w[0]), 2);
                repeat (43) begin @(posedge clk); #1; end
                @(negedge clk);
                check("midrst_busy_before", longint'(busy_w[0]), 1);
                rst_n[0] = 1'b0;
                #1;
                check("midrst_tx",    longint'(tx_w[0]),    1);
                check("midrst_level", longint'(level_w[0]), 0);
                check("midrst_busy",  longint'(busy_w[0]),  0);
                check("midrst_ready", longint'(rdy[0]),     1);
                repeat (2) @(negedge clk);
                rst_n[0] = 1'b1;
                a_low = 0;
                repeat (200) begin @(negedge clk); if (tx_w[0] !== 1'b1 || busy_w[0] !== 1'b0) a_low++; end
                check("midrst_quiet_clks", a_low, 0);
                check("midrst_level_after", longint'(level_w[0]), 0);
            end
            begin : seq_b
                int b_acc, b_len;
                push(1, 9'h05A, 16'b00101101001, 11, 50, b_acc);
                busy_len(1, 300, b_len);
                check("8e1_busy_clks", b_len, 110);
            end
            begin : seq_c
                int c_acc, c_len;
                push(2, 9'h05A, 16'b00101101011, 11, 50, c_acc);
                busy_len(2, 300, c_len);
                check("8o1_busy_clks", c_len, 110);
            end
            begin : seq_d
                int d_acc, d_len;
                push(3, 9'h041, 16'b01000001111, 11, 50, d_acc);
                busy_len(3, 300, d_len);
                check("7o2_busy_clks", d_len, 110);
            end
            begin : seq_e
                int e_acc, e_i, e_low, e_end;
                push(4, 9'h0A5, 16'b0101001011, 10, 50, e_acc);
                e_i = 0;
                while (tx_w[4] !== 1'b0 && e_i < 20) begin @(negedge clk); e_i++; end
                e_low = 0;
                while (tx_w[4] === 1'b0 && e_low < 6000) begin e_low++; @(negedge clk); end
                check("dflt_start_bit_clks", e_low, 5208);
                wait_idle(4, 60000, e_end);
                check("dflt_frame_clks", e_end - e_acc, 52081);
            end
        join

        repeat (20) @(negedge clk);
        bad = 0;
        for (int i = 0; i < 5; i++)
            check($sformatf("drained_%0d", i), exp_q[i].size(), 0);
        check("frames_a", start_log[0].size(), 8);
        n0 = 0;
        for (int i = 1; i < 5; i++) if (start_log[i].size() != 1) n0++;
        check("frames_bcde_not_one", n0, bad);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
